// File: rtl/axi_lite_timer_if.sv
// AXI4-lite responder bundle for the timer block.
// master drives addr/data/valid + bready/rready; slave drives readys, bvalid, rvalid, rdata.
interface axi_lite_timer_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb,
        output bready, arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb,
        input  bready, arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, arready, rvalid, rdata
    );
endinterface

// File: rtl/axi_lite_timer.sv
// Down-counting AXI4-lite timer: prescaler, auto-reload, level irq.
// Ports: clk, rst (sync, active-high), axi (slave modport), timer_irq.
module axi_lite_timer #(
    parameter int CNT_W = 32,
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    axi_lite_timer_if.slave  axi,
    output logic             timer_irq
);

    logic [2:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pend_q, pend_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] pcnt_q, pcnt_d;
    logic             awrdy_q, awrdy_d;
    logic             bvalid_q, bvalid_d;
    logic             arrdy_q, arrdy_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;

    logic        wr_fire;
    logic        rd_fire;
    logic        tick;
    logic        hw_set;
    logic [3:0]  wr_sel;
    logic [3:0]  rd_sel;
    logic [31:0] wr_old;
    logic [31:0] wr_new;
    logic [31:0] rd_val;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  st
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = st[i] ? wd[8*i +: 8] : old[8*i +: 8];
        end
        return r;
    endfunction

    // aw and w share one ready, so the handshake edge is a single event.
    assign wr_fire = awrdy_q & axi.awvalid & axi.wvalid;
    assign rd_fire = arrdy_q & axi.arvalid;
    assign wr_sel  = axi.awaddr[3:0];
    assign rd_sel  = axi.araddr[3:0];
    assign tick    = ctrl_q[0] && (pcnt_q == pre_q);
    assign hw_set  = tick && (count_q == '0);

    always_comb begin
        wr_old = '0;
        case (wr_sel)
            4'd0:    wr_old = 32'(ctrl_q);
            4'd1:    wr_old = 32'(load_q);
            4'd4:    wr_old = 32'(pre_q);
            default: wr_old = '0;
        endcase
        wr_new = merge(wr_old, axi.wdata, axi.wstrb);
    end

    always_comb begin
        rd_val = '0;
        case (rd_sel)
            4'd0:    rd_val = 32'(ctrl_q);
            4'd1:    rd_val = 32'(load_q);
            4'd2:    rd_val = 32'(count_q);
            4'd3:    rd_val = 32'(pend_q);
            4'd4:    rd_val = 32'(pre_q);
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        load_d   = load_q;
        count_d  = count_q;
        pend_d   = pend_q;
        pre_d    = pre_q;
        awrdy_d  = axi.awvalid & axi.wvalid & ~bvalid_q & ~awrdy_q;
        arrdy_d  = axi.arvalid & ~rvalid_q & ~arrdy_q;
        bvalid_d = bvalid_q & ~axi.bready;
        rvalid_d = rvalid_q & ~axi.rready;
        rdata_d  = rdata_q;

        if (wr_fire) bvalid_d = 1'b1;
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
        end

        if (!ctrl_q[0] || tick) pcnt_d = '0;
        else                    pcnt_d = pcnt_q + 1'b1;

        if (tick) begin
            if (count_q != '0) count_d = count_q - 1'b1;
            else if (ctrl_q[1]) count_d = load_q;
            else ctrl_d[0] = 1'b0;
        end

        // Software writes land after the hardware update so they win.
        if (wr_fire) begin
            case (wr_sel)
                4'd0: begin
                    ctrl_d = wr_new[2:0];
                    pcnt_d = '0;
                end
                4'd1: begin
                    load_d  = wr_new[CNT_W-1:0];
                    count_d = wr_new[CNT_W-1:0];
                end
                4'd3: begin
                    if (axi.wstrb[0] && axi.wdata[0]) pend_d = 1'b0;
                end
                4'd4:    pre_d = wr_new[PRE_W-1:0];
                default: ;
            endcase
        end

        // Hardware set beats a coincident W1C.
        if (hw_set) pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= '0;
            load_q   <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
            pre_q    <= '0;
            pcnt_q   <= '0;
            awrdy_q  <= 1'b0;
            bvalid_q <= 1'b0;
            arrdy_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            load_q   <= load_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            pre_q    <= pre_d;
            pcnt_q   <= pcnt_d;
            awrdy_q  <= awrdy_d;
            bvalid_q <= bvalid_d;
            arrdy_q  <= arrdy_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign axi.awready = awrdy_q;
    assign axi.wready  = awrdy_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.arready = arrdy_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign timer_irq   = pend_q & ctrl_q[2];

    logic unused_bits;
    assign unused_bits = ^{axi.awaddr[31:4], axi.araddr[31:4],
                           axi.awprot, axi.arprot, wr_new};

endmodule

// File: doc/axi_lite_timer.md
Name: axi_lite_timer

Overview:
- AXI4-lite responder (slave) on the shared interconnect: down-counting timer with prescaler, auto-reload and a level interrupt into the picorv32 irq vector.
- Answers the CPU-initiated read/write transactions; word-addressed as the interconnect presents them (base already subtracted, byte address already shifted right by 2).
- Occupies a 16-word window (mask 0x0000000F).

Parameters:
- CNT_W, 32, width of the LOAD/COUNT registers (1..32; unused upper read bits are 0).
- PRE_W, 16, width of the PRESCALE register and prescaler counter.

Ports:
- clk  in  1  system clock (clk_100 domain).
- rst  in  1  synchronous, active-high reset.
- axi_awvalid  in  1  write address valid.
- axi_awready  out  1  write address ready.
- axi_awaddr  in  32  word offset; bits [3:0] decoded, upper bits ignored.
- axi_awprot  in  3  ignored.
- axi_wvalid  in  1  write data valid.
- axi_wready  out  1  write data ready.
- axi_wdata  in  32  write data.
- axi_wstrb  in  4  byte enables.
- axi_bvalid  out  1  write response valid (no bresp; always OKAY).
- axi_bready  in  1  write response ready.
- axi_arvalid  in  1  read address valid.
- axi_arready  out  1  read address ready.
- axi_araddr  in  32  word offset; bits [3:0] decoded.
- axi_arprot  in  3  ignored.
- axi_rvalid  out  1  read data valid.
- axi_rready  in  1  read data ready.
- axi_rdata  out  32  read data.
- timer_irq  out  1  level interrupt = STATUS.pend & CTRL.ie.

Behaviour:
- Registers (word offset):
  - 0 CTRL rw: bit0 en, bit1 reload, bit2 ie.
  - 1 LOAD rw.
  - 2 COUNT ro.
  - 3 STATUS: bit0 pend, write-1-to-clear.
  - 4 PRESCALE rw.
  - Offsets 5..15: reads return 0, writes are ignored but still acknowledged.
- Reset: all registers 0; prescaler counter 0; awready=wready=bvalid=arready=rvalid=0; rdata=0; timer_irq=0.
- Write channel:
  - awready and wready are pulsed together for exactly one cycle, only when awvalid & wvalid & !bvalid & !(aw/w ready already high).
  - The register update takes effect at that handshake edge.
  - bvalid rises the next cycle and holds until bready; no new write is accepted while bvalid=1.
  - If only one of awvalid/wvalid is high, nothing is accepted (wait for both).
- Byte strobes: each wstrb[i] gates wdata[8i+7:8i] on CTRL/LOAD/PRESCALE. STATUS clear uses wdata[0] only when wstrb[0]=1.
- LOAD write: also copies the new LOAD value into COUNT in the same cycle, overriding any decrement that cycle.
- Read channel:
  - arready pulses one cycle when arvalid & !rvalid & !arready.
  - rdata is registered from the decoded address at that edge; rvalid rises the next cycle and holds with rdata stable until rready.
  - Read and write may complete in the same cycle independently; a read of a register being written that cycle returns the pre-write value.
- Prescaler:
  - While en=1, it counts 0..PRESCALE; tick is asserted in the cycle it equals PRESCALE, then it wraps to 0.
  - PRESCALE=0 ticks every cycle.
  - While en=0 the prescaler is held at 0; a CTRL write setting en also clears it.
- Tick behaviour:
  - If COUNT != 0: COUNT decrements.
  - If COUNT == 0: pend<=1; if reload=1, COUNT<=LOAD, otherwise en<=0.
  - LOAD=0 with reload=1 therefore sets pend on every tick.
- Simultaneous events:
  - Hardware pend set and software W1C in the same cycle: set wins (pend=1).
  - Software CTRL write and hardware en-clear in the same cycle: software value wins.
- Reset mid-transaction aborts it: bvalid/rvalid drop the next cycle and no register update occurs.
- Latency: write address/data to bvalid = 1 cycle after the handshake; arvalid to rvalid = 2 cycles minimum.

Test Plan:
- Reset, then read offsets 0..4 with rready=1 -> rdata=0 each time, rvalid 2 cycles after arvalid, timer_irq=0.
- Write LOAD=5, PRESCALE=0, CTRL=0x5 -> COUNT reads 5,4,...,0; pend=1 and timer_irq=1 exactly 6 cycles after enable; en reads back 0; W1C STATUS=1 -> irq drops next cycle.
- CTRL=0x7, LOAD=2, PRESCALE=3 -> pend set every 12 cycles; hold a W1C coincident with a hardware set -> pend stays 1.
- Write LOAD=0xAABBCCDD then write 0x11223344 with wstrb=0b0101 -> LOAD reads 0xAA22CC44.
- Hold bready=0 for 10 cycles after a write -> bvalid stays 1, awready/wready stay 0 against a second write; that write is accepted only after bready. Same check for rvalid/rready with rdata held stable.
- Present awvalid without wvalid for 5 cycles -> no awready; raise wvalid -> both readys pulse together. Write offset 9 -> bvalid returns, no register changes.
